// File: rtl/button_pkg.sv
// Shared constants for the board-game button front end: command codes,
// counter width and a constant-evaluable clog2.
package button_pkg;

  typedef enum int unsigned {
    CODE_NONE = 0,
    RIGHT     = 1,
    LEFT      = 2,
    DOWN      = 3,
    UP        = 4,
    DECIDE    = 5,
    RED_RST   = 6,
    BLUE_RST  = 7
  } btn_code_e;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, tick-based debounce,
// press-edge detect and optional auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 250,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rep
);

  logic             sync1, sync2;
  logic             level_q;
  logic             rep_phase;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] rcount;
  logic [CNT_W-1:0] rtarget;

  // rep_phase selects between the initial hold delay and the repeat period
  assign rtarget = rep_phase ? CNT_W'(REPEAT_RATE_MS - 1) : CNT_W'(REPEAT_DELAY_MS - 1);
  assign press   = level & ~level_q;
  assign rep     = REPEAT_EN & level & ~press & tick & (rcount == rtarget);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      count     <= '0;
      rcount    <= '0;
      rep_phase <= 1'b0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_q <= level;

      if (sync2 == level) begin
        count <= '0;
      end else if (tick) begin
        if (count == CNT_W'(DEBOUNCE_MS - 1)) begin
          level <= sync2;
          count <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end

      if (!level || press) begin
        rcount    <= '0;
        rep_phase <= 1'b0;
      end else if (tick) begin
        if (rcount == rtarget) begin
          rcount    <= '0;
          rep_phase <= 1'b1;
        end else begin
          rcount <= rcount + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_frontend.sv
// N-channel button conditioner: ms-tick prescaler, per-channel debounce/repeat,
// highest-index priority encode into a one-entry valid/ready command register.
module button_frontend
  import button_pkg::*;
#(
  parameter int unsigned          NUM_BTN         = 7,
  parameter int unsigned          CLK_HZ          = 50_000_000,
  parameter int unsigned          DEBOUNCE_MS     = 20,
  parameter int unsigned          REPEAT_DELAY_MS = 500,
  parameter int unsigned          REPEAT_RATE_MS  = 250,
  parameter logic [NUM_BTN-1:0]   REPEAT_EN       = 7'b0001111,
  parameter int unsigned          CODE_W          = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               cmd_ready,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               cmd_valid,
  output logic [CODE_W-1:0]  cmd_code,
  output logic               cmd_repeat,
  output logic               overflow
);

  localparam int unsigned DIV     = CLK_HZ / 1000;
  localparam int unsigned PRESC_W = clog2(DIV);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [NUM_BTN-1:0] rep;
  logic [NUM_BTN-1:0] ev;
  logic [CODE_W-1:0]  next_code;
  logic               next_rep;

  assign tick = (presc == PRESC_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PRESC_W'(1);
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .REPEAT_EN       (REPEAT_EN[g])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .btn_in  (btn_in[g]),
      .level   (btn_level[g]),
      .press   (btn_press[g]),
      .rep     (rep[g])
    );
  end

  // ascending scan so the highest set index overwrites lower ones
  always_comb begin
    ev        = btn_press | rep;
    next_code = CODE_W'(CODE_NONE);
    next_rep  = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (ev[i]) begin
        next_code = CODE_W'(i + 1);
        next_rep  = rep[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= CODE_W'(CODE_NONE);
      cmd_repeat <= 1'b0;
      overflow   <= 1'b0;
    end else if (ev != '0) begin
      if (!cmd_valid || cmd_ready) begin
        cmd_valid  <= 1'b1;
        cmd_code   <= next_code;
        cmd_repeat <= next_rep;
      end else begin
        overflow <= 1'b1;
      end
    end else if (cmd_ready) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= CODE_W'(CODE_NONE);
      cmd_repeat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_frontend.sv
// Scoreboard bench for button_frontend: a tick/time-based reference model pushes
// expected commands, a negedge monitor pops them as the DUT presents commands.
module tb_button_frontend;

  localparam int NUM_BTN = 7;
  localparam int CLK_HZ  = 4000;
  localparam int DEB     = 3;
  localparam int RDEL    = 5;
  localparam int RRATE   = 2;
  localparam int CODE_W  = 4;
  localparam int DIV     = CLK_HZ / 1000;
  localparam logic [NUM_BTN-1:0] REN = 7'b0001111;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_BTN-1:0] btn_in;
  logic               cmd_ready;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic               cmd_valid;
  logic [CODE_W-1:0]  cmd_code;
  logic               cmd_repeat;
  logic               overflow;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  button_frontend #(
    .NUM_BTN         (NUM_BTN),
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_MS     (DEB),
    .REPEAT_DELAY_MS (RDEL),
    .REPEAT_RATE_MS  (RRATE),
    .REPEAT_EN       (REN),
    .CODE_W          (CODE_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .cmd_ready  (cmd_ready),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_repeat (cmd_repeat),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              rep;
  } cmd_t;

  cmd_t exp_q[$];

  // Reference model: sync history, debounce by tick numbers since a mismatch
  // began, repeats by tick distance from the press.
  logic [NUM_BTN-1:0] m_s1, m_s2, m_level, m_pflag, m_pend;
  int                 m_t0[NUM_BTN];
  int                 m_p[NUM_BTN];
  int                 m_n, m_T;
  logic               m_v, m_rep, m_ovf;
  logic [CODE_W-1:0]  m_code;

  always @(posedge clk) begin : model
    logic               tick;
    logic [NUM_BTN-1:0] ev, rp;
    int                 top, k;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pflag = '0; m_pend = '0;
      m_n = 0; m_T = 0;
      m_v = 1'b0; m_code = '0; m_rep = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      tick = ((m_n % DIV) == DIV - 1);
      rp = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (m_pflag[i]) m_p[i] = m_T;
        k = m_T + 1 - m_p[i];
        if (tick && REN[i] && m_level[i] && !m_pflag[i] && k >= RDEL && ((k - RDEL) % RRATE) == 0)
          rp[i] = 1'b1;
      end
      ev  = m_pflag | rp;
      top = -1;
      for (int i = NUM_BTN - 1; i >= 0; i--)
        if (ev[i] && top < 0) top = i;
      if (top >= 0) begin
        if (!m_v || cmd_ready) begin
          m_v = 1'b1; m_code = CODE_W'(top + 1); m_rep = rp[top];
          exp_q.push_back(cmd_t'{code: m_code, rep: m_rep});
        end else begin
          m_ovf = 1'b1;
        end
      end else if (cmd_ready) begin
        m_v = 1'b0; m_code = '0; m_rep = 1'b0;
      end
      m_pflag = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (m_s2[i] == m_level[i]) begin
          m_pend[i] = 1'b0;
        end else begin
          if (!m_pend[i]) begin m_pend[i] = 1'b1; m_t0[i] = m_T; end
          if (tick && (m_T + 1 - m_t0[i]) == DEB) begin
            m_level[i] = m_s2[i];
            m_pend[i]  = 1'b0;
            if (m_s2[i]) m_pflag[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
      if (tick) m_T++;
      m_n++;
    end
  end

  int   press_cnt[NUM_BTN];
  int   cmd_cnt = 0, rep_cnt = 0;
  int   last_code = 0, last_rep = 0;
  logic pv = 1'b0, pr = 1'b0;

  always @(negedge clk) begin : monitor
    cmd_t got, e;
    if (armed) begin
      if (cmd_valid && (!pv || pr)) begin
        got = cmd_t'{code: cmd_code, rep: cmd_repeat};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got code=%0d rep=%0d, required no command", cmd_code, cmd_repeat);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL cmd: got code=%0d rep=%0d, required code=%0d rep=%0d", got.code, got.rep, e.code, e.rep);
          end
        end
        cmd_cnt++;
        if (cmd_repeat) rep_cnt++;
        last_code = int'(cmd_code);
        last_rep  = int'(cmd_repeat);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL cmd_missing: got no command, required %0d pending", exp_q.size());
        exp_q.delete();
      end
      checks++;
      if (cmd_valid !== m_v || overflow !== m_ovf || btn_level !== m_level ||
          btn_press !== m_pflag || cmd_code !== m_code || cmd_repeat !== m_rep) begin
        errors++;
        $display("FAIL state @%0t: got v=%b ovf=%b lvl=%b prs=%b code=%0d rep=%b, required v=%b ovf=%b lvl=%b prs=%b code=%0d rep=%b",
                 $time, cmd_valid, overflow, btn_level, btn_press, cmd_code, cmd_repeat,
                 m_v, m_ovf, m_level, m_pflag, m_code, m_rep);
      end
      for (int i = 0; i < NUM_BTN; i++)
        if (btn_press[i]) press_cnt[i]++;
    end
    pv = cmd_valid;
    pr = cmd_ready;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic wait_level(input string name, input logic [NUM_BTN-1:0] mask, input int budget, output int cycles);
    cycles = 0;
    while (((btn_level & mask) != mask) && cycles < budget) begin
      step(1);
      cycles++;
    end
    chk(name, int'((btn_level & mask) == mask), 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c;
    c = 0;
    while (!cmd_valid && c < budget) begin
      step(1);
      c++;
    end
    chk(name, int'(cmd_valid), 1);
  endtask

  int cyc, c0, c1, p0, r0;

  initial begin
    reset_n = 1'b0; btn_in = '1; cmd_ready = 1'b1;
    step(1);
    armed = 1'b1;
    step(2);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_code", int'(cmd_code), 0);
    chk("reset_repeat", int'(cmd_repeat), 0);
    chk("reset_overflow", int'(overflow), 0);

    reset_n = 1'b1;
    wait_level("all_level_timeout", '1, 2 + (DEB + 1) * DIV + 2, cyc);
    step(1);
    chk("all_press_code", int'(cmd_code), 7);
    chk("all_press_valid", int'(cmd_valid), 1);
    btn_in = '0;
    step(40);

    // bounce on channel 3
    p0 = press_cnt[3];
    btn_in[3] = 1'b1; step(DIV);
    btn_in[3] = 1'b0; step(DIV);
    btn_in[3] = 1'b1;
    wait_level("bounce_level_timeout", 7'b0001000, 2 + (DEB + 1) * DIV + 2, cyc);
    chk("bounce_not_early", int'(cyc >= 2 * DIV), 1);
    step(4);
    chk("bounce_press_count", press_cnt[3] - p0, 1);
    chk("bounce_code", last_code, 4);
    btn_in = '0;
    step(40);

    // auto-repeat on channel 0
    c0 = cmd_cnt; r0 = rep_cnt;
    btn_in[0] = 1'b1;
    step(80);
    btn_in = '0;
    step(30);
    c1 = cmd_cnt;
    chk("repeat_cmds", int'((c1 - c0) >= 4), 1);
    chk("repeat_flagged", int'((rep_cnt - r0) >= 3), 1);
    step(30);
    chk("no_cmd_after_release", cmd_cnt - c1, 0);

    // channel 5 never repeats
    c0 = cmd_cnt;
    btn_in[5] = 1'b1;
    step(20 * DIV);
    chk("norepeat_count", cmd_cnt - c0, 1);
    chk("norepeat_code", last_code, 6);
    chk("norepeat_flag", last_rep, 0);
    btn_in = '0;
    step(30);

    // overflow with consumer stalled
    cmd_ready = 1'b0;
    btn_in[2] = 1'b1;
    wait_valid("stall_valid_timeout", 30);
    chk("stall_code_first", int'(cmd_code), 3);
    btn_in[4] = 1'b1;
    step(30);
    chk("stall_code_held", int'(cmd_code), 3);
    chk("stall_overflow", int'(overflow), 1);
    btn_in = '0;
    step(40);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("accept_clears_valid", int'(cmd_valid), 0);
    cmd_ready = 1'b1;

    // simultaneous presses, then reset while pending
    reset_n = 1'b0; step(2);
    reset_n = 1'b1; step(2);
    chk("overflow_cleared", int'(overflow), 0);
    cmd_ready = 1'b0;
    btn_in = 7'b0010010;
    wait_valid("simul_valid_timeout", 30);
    chk("simul_code", int'(cmd_code), 5);
    chk("simul_no_overflow", int'(overflow), 0);
    step(2);
    reset_n = 1'b0;
    step(1);
    chk("reset_drops_cmd", int'(cmd_valid), 0);
    reset_n = 1'b1; btn_in = '0; cmd_ready = 1'b1;
    step(40);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      btn_in    = btn_in ^ (NUM_BTN'($urandom) & NUM_BTN'($urandom) & NUM_BTN'($urandom));
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
      step($urandom_range(1, 12));
      reset_n = 1'b1;
    end
    btn_in = '0; cmd_ready = 1'b1;
    step(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
